// File: rtl/cpu_hold_pkg.sv
// Shared types and defaults for the CPU-side HOLD/HLDA responder (8237 DMA bus handover).
package cpu_hold_pkg;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_MAX_HOLD = 1024;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HELD   = 2'd2,
        RESUME = 2'd3
    } hold_state_t;

    typedef struct packed {
        logic hlda;
        logic bus_grant;
        logic pc_hold;
        logic bubble_id;
    } hold_ctl_t;

    // Moore output decode; applied to the next state so the outputs come straight off flops.
    function automatic hold_ctl_t decode_state(input logic [1:0] st);
        hold_ctl_t c;
        c           = '0;
        c.pc_hold   = (st != RUN);
        c.bubble_id = (st != RUN);
        c.hlda      = (st == HELD);
        c.bus_grant = (st == HELD);
        return c;
    endfunction

endpackage

// File: rtl/cpu_hold_ctrl_if.sv
// Handshake bundle between the pipeline/DMA side and the hold controller.
interface cpu_hold_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             hrq;
    logic             mem_op_ex;
    logic             mem_op_mem;
    logic             hlda;
    logic             bus_grant;
    logic             pc_hold;
    logic             bubble_id;
    logic [CNT_W-1:0] hold_count;
    logic             hold_timeout;

    modport master (
        output hrq, mem_op_ex, mem_op_mem,
        input  hlda, bus_grant, pc_hold, bubble_id, hold_count, hold_timeout
    );

    modport slave (
        input  hrq, mem_op_ex, mem_op_mem,
        output hlda, bus_grant, pc_hold, bubble_id, hold_count, hold_timeout
    );
endinterface

// File: rtl/cpu_hold_ctrl.sv
// HOLD/HLDA responder: drains EX/MEM memory ops, then hands the data bus to the DMA.
// Optional HELD-duration watchdog enabled by defining HOLD_WDOG_EN.
module cpu_hold_ctrl
    import cpu_hold_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input logic             clk,
    input logic             rst,
    cpu_hold_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_RUN    = RUN;
    localparam logic [1:0] ST_DRAIN  = DRAIN;
    localparam logic [1:0] ST_HELD   = HELD;
    localparam logic [1:0] ST_RESUME = RESUME;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    hold_ctl_t        ctl_q;
    hold_ctl_t        ctl_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.hrq) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A dropped request wins over a pipe that happens to be empty.
                if (!bus.hrq)
                    state_d = ST_RUN;
                else if (!bus.mem_op_ex && !bus.mem_op_mem)
                    state_d = ST_HELD;
            end
            ST_HELD: begin
                if (!bus.hrq) state_d = ST_RESUME;
            end
            ST_RESUME: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign ctl_d = decode_state(state_d);

    always_comb begin
        count_d = count_q;
        if (state_q == ST_DRAIN && state_d == ST_HELD)
            count_d = '0;
        else if (state_q == ST_HELD && count_q != '1)
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            ctl_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            count_q <= count_d;
        end
    end

`ifdef HOLD_WDOG_EN
    localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(MAX_HOLD);

    logic timeout_q;

    // Sticky flag only; the grant continues until the DMA drops hrq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout_q <= 1'b0;
        else if (state_q == ST_HELD && {1'b0, count_d} >= LIMIT)
            timeout_q <= 1'b1;
    end

    assign bus.hold_timeout = timeout_q;
`else
    assign bus.hold_timeout = 1'b0;
`endif

    assign bus.hlda       = ctl_q.hlda;
    assign bus.bus_grant  = ctl_q.bus_grant;
    assign bus.pc_hold    = ctl_q.pc_hold;
    assign bus.bubble_id  = ctl_q.bubble_id;
    assign bus.hold_count = count_q;

endmodule

// File: doc/cpu_hold_ctrl.md
# cpu_hold_ctrl

CPU-side HOLD/HLDA responder for the 8237 DMA controller. It answers the DMA's bus request by freezing instruction fetch, draining in-flight data-memory accesses from the EX and MEM pipeline stages, and then granting the data-memory bus with HLDA. When the DMA drops HRQ, it returns the bus and resumes the pipeline. It sits beside the hazard detection unit and drives the PC/IF-ID hold, the ID/EX bubble and the data-memory ownership mux.

## Interface
Parameters:
- CNT_W, 16, width of the hold-cycle counter
- MAX_HOLD, 1024, HELD-cycle limit for the watchdog (used only with the macro defined)

Ports:
- clk  in  1  pipeline clock; all state changes on posedge
- rst  in  1  reset; asynchronous, active-high
- hrq  in  1  hold request from the DMA controller
- mem_op_ex  in  1  EX stage holds a load/store (memRead | memWrite, EX)
- mem_op_mem  in  1  MEM stage holds a load/store (memRead | memWrite, MEM)
- hlda  out  1  hold acknowledge to the DMA controller
- bus_grant  out  1  data-memory address/data/control mux selects DMA side
- pc_hold  out  1  freeze PC and IF/ID; suppresses branch and jump PC updates
- bubble_id  out  1  force zero controls into ID/EX, same path as the hazard mux
- hold_count  out  CNT_W  HELD cycles in the current or most recent grant
- hold_timeout  out  1  sticky watchdog flag

## Operation
- All outputs are registered Moore decodes of the state, plus the registered counter and flag.
- States: RUN, DRAIN, HELD, RESUME. Reset puts the block in RUN with every output at 0 and hold_count at 0.
- RUN: all control outputs are 0.
  - hrq=1 → DRAIN.
- DRAIN: pc_hold=1, bubble_id=1, hlda=0, bus_grant=0.
  - hrq=0 → RUN. This aborts the drain; no hlda is issued.
  - hrq=1 and mem_op_ex=0 and mem_op_mem=0 → HELD.
  - Otherwise stay in DRAIN.
- HELD: pc_hold=1, bubble_id=1, hlda=1, bus_grant=1.
  - hrq=0 → RESUME.
- RESUME: pc_hold=1, bubble_id=1, hlda=0, bus_grant=0. This is a one-cycle bus turnaround.
  - Always → RUN, regardless of hrq.
  - The guaranteed RUN cycle lets the CPU advance at least one instruction between back-to-back grants, so the CPU cannot be starved.
- The ID-stage instruction stays frozen in IF/ID during the hold. Any branch or jump it carries is re-evaluated after RUN resumes; no flush is generated by this block.
- hold_count:
  - Cleared to 0 on the DRAIN→HELD transition.
  - Incremented on each HELD cycle.
  - Saturates at all-ones.
  - Holds its value outside HELD.
- Simultaneous events: in DRAIN, the hrq=0 abort has priority over the drain-complete condition.
- Reset asserted mid-grant: hlda and bus_grant drop immediately (asynchronous), and the state returns to RUN.

## Timing
- hrq rising at edge N: DRAIN from edge N. pc_hold and bubble_id are visible after edge N.
- Minimum request-to-hlda latency is 2 edges (one DRAIN cycle with an empty pipe). Each pending EX or MEM memory op adds cycles until both inputs read 0.
- hrq falling sampled at edge M in HELD: hlda=0 and bus_grant=0 after edge M. pc_hold=0 after edge M+1.
- hlda and bus_grant always change on the same edge.
- bus_grant is never 1 while mem_op_mem=1.

## Configuration
- HOLD_WDOG_EN defined:
  - hold_timeout sets when hold_count reaches MAX_HOLD while in HELD.
  - It stays set until rst; the grant itself is not revoked.
- HOLD_WDOG_EN undefined:
  - hold_timeout is tied to 0 and MAX_HOLD is unused.
  - hold_count still operates.

## Structure
- Shared package cpu_hold_pkg contains:
  - state enum (RUN=2'd0, DRAIN=2'd1, HELD=2'd2, RESUME=2'd3)
  - default CNT_W and MAX_HOLD constants
- No sub-module. The FSM, counter and watchdog compare live in one module.

## Test plan
- Empty pipe: hrq=1 at edge 3 → pc_hold=1 after edge 3, hlda=1 after edge 4. Release hrq at edge 10 → hlda=0 after edge 10, pc_hold=0 after edge 11.
- Store in flight: mem_op_mem=1 for 2 cycles after the request → hlda is delayed 2 extra cycles, and bus_grant stays 0 throughout.
- Abort: hrq=1 for one cycle during DRAIN with mem_op_ex=1 → return to RUN, hlda never pulses.
- Back-to-back: hrq held high across a release attempt (0 for one cycle) → sequence RESUME, RUN (pc_hold=0 for exactly 1 cycle), DRAIN, HELD; hold_count restarts at 0.
- Watchdog with HOLD_WDOG_EN, MAX_HOLD=8, hold for 20 cycles → hold_timeout=1 after the 8th HELD cycle and stays 1 after release. Without the macro, hold_timeout stays 0.
- Async rst pulse while HELD → hlda, bus_grant, pc_hold and hold_count all read 0 before the next clk edge.
